bs_rr_arbiter_router: RTL and testbench

//  Next-generation bus arbiter/router for the DRVRS-port shared bus.
//  - Polls the per-port FIFO pending flags and grants one port at a time, round-robin.
//  - Pops one packet from the granted port, decodes its destination ID and pushes it to that port.
//  - A broadcast packet goes to every port except the source.
//  - Adds destination back-pressure (full_i), invalid-ID drop with a counter, and parametrised ID width.

---
 rtl/bs_rr_arbiter_router.sv | 214 +++++++++++++++++++++
 tb/tb_bs_rr_arbiter_router.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bs_rr_arbiter_router.sv
// Round-robin bus arbiter/router: grants one pending port at a time, pops its
// head packet, decodes the destination ID and pushes it (unicast or broadcast).
module bs_rr_arbiter_router #(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
    parameter int              CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    input  logic [DRVRS-1:0]           full_i,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic                       drop,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       busy
);

    localparam int PW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        DELIVER = 3'd2,
        PUSH    = 3'd3,
        DROP    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
    logic [PW-1:0]        src_q, src_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [DRVRS-1:0]     mask_q, mask_d;
    logic [DRVRS-1:0]     pop_q, pop_d;
    logic [DRVRS-1:0]     push_q, push_d;
    logic [PCKG_SZ-1:0]   d_push_q, d_push_d;
    logic                 drop_q, drop_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic                 busy_q, busy_d;

    logic                 grant_vld_s;
    logic [PW-1:0]        grant_idx_s;
    logic [PCKG_SZ-1:0]   win_pkt_s;
    logic [ID_W-1:0]      id_s;
    logic [31:0]          id_ext_s;
    logic [DRVRS-1:0]     dec_mask_s;
    logic                 dec_ok_s;

    // Round-robin search starting one past the last winner, wrapping at DRVRS.
    always_comb begin
        logic [PW:0]   sum_v;
        logic [PW-1:0] idx_v;
        grant_vld_s = 1'b0;
        grant_idx_s = ptr_q;
        for (int k = 1; k <= DRVRS; k++) begin
            sum_v = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum_v >= (PW+1)'(DRVRS)) begin
                idx_v = PW'(sum_v - (PW+1)'(DRVRS));
            end else begin
                idx_v = PW'(sum_v);
            end
            if (!grant_vld_s && pndng[idx_v]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx_v;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Select the head packet of the winning port.
    always_comb begin
        win_pkt_s = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (grant_idx_s == PW'(i)) begin
                win_pkt_s = D_pop[i*PCKG_SZ +: PCKG_SZ];
            end else begin
                win_pkt_s = win_pkt_s;
            end
        end
    end

    assign id_s     = pkt_q[PCKG_SZ-1 -: ID_W];
    assign id_ext_s = 32'(id_s);

    // Destination decode: unicast (self allowed), broadcast excluding source, else invalid.
    always_comb begin
        dec_mask_s = '0;
        dec_ok_s   = 1'b0;
        if (id_ext_s < 32'(DRVRS)) begin
            dec_mask_s[id_ext_s[PW-1:0]] = 1'b1;
            dec_ok_s                     = 1'b1;
        end else if ((id_s == BROADCAST) && (DRVRS > 1)) begin
            for (int i = 0; i < DRVRS; i++) begin
                dec_mask_s[i] = (src_q != PW'(i));
            end
            dec_ok_s = 1'b1;
        end else begin
            dec_ok_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_vld_s ? POP : IDLE;
            POP:     state_d = dec_ok_s ? DELIVER : DROP;
            DELIVER: state_d = (|(mask_q & full_i)) ? DELIVER : PUSH;
            PUSH:    state_d = IDLE;
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        pkt_d      = pkt_q;
        src_d      = src_q;
        ptr_d      = ptr_q;
        mask_d     = mask_q;
        pop_d      = '0;
        push_d     = '0;
        d_push_d   = '0;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (grant_vld_s) begin
                    pkt_d              = win_pkt_s;
                    src_d              = grant_idx_s;
                    ptr_d              = grant_idx_s;
                    pop_d[grant_idx_s] = 1'b1;
                end else begin
                    pkt_d = pkt_q;
                end
            end
            POP: begin
                mask_d = dec_mask_s;
                if (!dec_ok_s) begin
                    drop_d = 1'b1;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end else begin
                        drop_cnt_d = drop_cnt_q;
                    end
                end else begin
                    drop_d = 1'b0;
                end
            end
            DELIVER: begin
                // All-or-none: a broadcast waits until every target has room.
                if (!(|(mask_q & full_i))) begin
                    push_d   = mask_q;
                    d_push_d = pkt_q;
                end else begin
                    push_d = '0;
                end
            end
            default: begin
                pop_d = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q      <= '0;
            src_q      <= '0;
            ptr_q      <= PW'(DRVRS - 1);
            mask_q     <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            d_push_q   <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            pkt_q      <= pkt_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
            mask_q     <= mask_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            d_push_q   <= d_push_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign drop     = drop_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bs_rr_arbiter_router.sv
// Directed bench for bs_rr_arbiter_router: a vector table of single-packet
// transactions plus hand-written sequences for stall, round-robin and reset cases.
module tb_bs_rr_arbiter_router;

    logic        clk;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] d_pop;
    logic [3:0]  full_i;
    logic [3:0]  pop, push;
    logic [15:0] d_push;
    logic        drop, busy;
    logic [15:0] drop_cnt;

    logic [3:0]  pop_s2, push_s2;
    logic [15:0] d_push_s2;
    logic        drop_s2, busy_s2;
    logic [1:0]  drop_cnt_s2;

    int n_chk  = 0;
    int n_fail = 0;

    bs_rr_arbiter_router dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
        .full_i(full_i), .push(push), .D_push(d_push), .drop(drop),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    bs_rr_arbiter_router #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop_s2),
        .full_i(full_i), .push(push_s2), .D_push(d_push_s2), .drop(drop_s2),
        .drop_cnt(drop_cnt_s2), .busy(busy_s2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  pndng;
        logic [63:0] dpop;
        logic [3:0]  exp_pop;
        logic [3:0]  exp_push;
        logic [15:0] exp_dpush;
        logic        exp_drop;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic run_vec(input int n);
        logic [1:0] sat_exp;
        sat_exp = (vecs[n].exp_cnt > 16'd3) ? 2'd3 : vecs[n].exp_cnt[1:0];
        pndng  = vecs[n].pndng;
        d_pop  = vecs[n].dpop;
        full_i = 4'b0000;
        @(negedge clk);
        chk($sformatf("v%0d_pop", n), pop, vecs[n].exp_pop);
        chk($sformatf("v%0d_busy", n), busy, 1'b1);
        pndng = 4'b0000;
        @(negedge clk);
        chk($sformatf("v%0d_pop_clr", n), pop, 4'b0000);
        chk($sformatf("v%0d_push_early", n), push, 4'b0000);
        chk($sformatf("v%0d_drop", n), drop, vecs[n].exp_drop);
        chk($sformatf("v%0d_cnt", n), drop_cnt, vecs[n].exp_cnt);
        chk($sformatf("v%0d_cnt_sat", n), drop_cnt_s2, sat_exp);
        @(negedge clk);
        chk($sformatf("v%0d_push", n), push, vecs[n].exp_push);
        chk($sformatf("v%0d_dpush", n), d_push, vecs[n].exp_dpush);
        chk($sformatf("v%0d_drop_clr", n), drop, 1'b0);
        if (!vecs[n].exp_drop) begin
            @(negedge clk);
            chk($sformatf("v%0d_push_clr", n), push, 4'b0000);
            chk($sformatf("v%0d_dpush_clr", n), d_push, 16'h0000);
        end
        chk($sformatf("v%0d_idle", n), busy, vecs[n].exp_drop ? 1'b0 : 1'b0);
    endtask

    logic [3:0]  pq[$];
    int          pc[$];
    logic [3:0]  uq[$];
    logic [15:0] ud[$];

    initial begin
        //            pndng    D_pop {p3,p2,p1,p0}                            pop      push     D_push    drp   cnt
        vecs[0]  = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h02AB}, 4'b0001, 4'b0100, 16'h02AB, 1'b0, 16'd0};
        vecs[1]  = '{4'b1000, {16'h0112, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 4'b0010, 16'h0112, 1'b0, 16'd0};
        vecs[2]  = '{4'b0110, {16'h0000, 16'h0344, 16'h0033, 16'h0000}, 4'b0010, 4'b0001, 16'h0033, 1'b0, 16'd0};
        vecs[3]  = '{4'b0110, {16'h0000, 16'h0344, 16'h0033, 16'h0000}, 4'b0100, 4'b1000, 16'h0344, 1'b0, 16'd0};
        vecs[4]  = '{4'b1001, {16'h0266, 16'h0000, 16'h0000, 16'h0155}, 4'b1000, 4'b0100, 16'h0266, 1'b0, 16'd0};
        vecs[5]  = '{4'b0100, {16'h0000, 16'h0277, 16'h0000, 16'h0000}, 4'b0100, 4'b0100, 16'h0277, 1'b0, 16'd0};
        vecs[6]  = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFF01}, 4'b0001, 4'b1110, 16'hFF01, 1'b0, 16'd0};
        vecs[7]  = '{4'b0010, {16'h0000, 16'h0000, 16'h07CD, 16'h0000}, 4'b0010, 4'b0000, 16'h0000, 1'b1, 16'd1};
        vecs[8]  = '{4'b1000, {16'h0499, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 4'b0000, 16'h0000, 1'b1, 16'd2};
        vecs[9]  = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFE00}, 4'b0001, 4'b0000, 16'h0000, 1'b1, 16'd3};
        vecs[10] = '{4'b0010, {16'h0000, 16'h0000, 16'h07CD, 16'h0000}, 4'b0010, 4'b0000, 16'h0000, 1'b1, 16'd4};
        vecs[11] = '{4'b0100, {16'h0000, 16'h0800, 16'h0000, 16'h0000}, 4'b0100, 4'b0000, 16'h0000, 1'b1, 16'd5};

        reset  = 1'b1;
        pndng  = 4'b0000;
        d_pop  = 64'h0;
        full_i = 4'b0000;

        // Reset held five cycles: everything quiet.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_pop", pop, 4'b0000);
            chk("rst_push", push, 4'b0000);
            chk("rst_dpush", d_push, 16'h0000);
            chk("rst_drop", drop, 1'b0);
            chk("rst_cnt", drop_cnt, 16'd0);
            chk("rst_busy", busy, 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        for (int n = 0; n < 12; n++) begin
            run_vec(n);
        end

        // Fresh reset so round-robin starts at port 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst2_cnt", drop_cnt, 16'd0);

        pndng = 4'b1111;
        d_pop = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (pop != 4'b0000) begin
                pq.push_back(pop);
                pc.push_back(c);
            end
            if (push != 4'b0000) begin
                uq.push_back(push);
                ud.push_back(d_push);
            end
        end
        pndng = 4'b0000;
        chk("rr_pop_count", 64'(pq.size()), 64'd8);
        chk("rr_push_count", 64'(uq.size()), 64'd8);
        for (int i = 0; i < 8 && i < pq.size(); i++) begin
            chk($sformatf("rr_pop%0d", i), pq[i], 4'b0001 << (i % 4));
            chk($sformatf("rr_cyc%0d", i), 64'(pc[i]), 64'(4 * i));
        end
        for (int i = 0; i < 8 && i < uq.size(); i++) begin
            chk($sformatf("rr_push%0d", i), uq[i], 4'b0001);
            chk($sformatf("rr_dpush%0d", i), ud[i], 16'h00A0 + 16'(i % 4));
        end
        @(negedge clk);
        chk("rr_idle", busy, 1'b0);

        // Broadcast from port 2 stalls while port 1 is full.
        pndng  = 4'b0100;
        d_pop  = {16'h0000, 16'hFF55, 16'h0000, 16'h0000};
        full_i = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("bc_pop", pop, 4'b0100);
                pndng = 4'b0000;
            end
            chk($sformatf("bc_stall_push%0d", c), push, 4'b0000);
            chk($sformatf("bc_stall_busy%0d", c), busy, 1'b1);
        end
        full_i = 4'b0000;
        @(negedge clk);
        chk("bc_push", push, 4'b1011);
        chk("bc_dpush", d_push, 16'hFF55);
        @(negedge clk);
        chk("bc_push_clr", push, 4'b0000);
        chk("bc_dpush_clr", d_push, 16'h0000);
        chk("bc_idle", busy, 1'b0);

        // Reset while stalled in DELIVER; port 0 then beats port 3.
        pndng  = 4'b0001;
        d_pop  = {16'h0133, 16'h0000, 16'h0000, 16'h0201};
        full_i = 4'b0100;
        @(negedge clk);
        chk("mr_pop", pop, 4'b0001);
        pndng = 4'b1001;
        @(negedge clk);
        chk("mr_busy", busy, 1'b1);
        chk("mr_push_stall", push, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_rst_busy", busy, 1'b0);
        chk("mr_rst_push", push, 4'b0000);
        chk("mr_rst_pop", pop, 4'b0000);
        reset  = 1'b0;
        full_i = 4'b0000;
        @(negedge clk);
        chk("mr_retry_pop", pop, 4'b0001);
        pndng = 4'b0000;
        @(negedge clk);
        chk("mr_retry_push_early", push, 4'b0000);
        @(negedge clk);
        chk("mr_retry_push", push, 4'b0100);
        chk("mr_retry_dpush", d_push, 16'h0201);
        @(negedge clk);
        chk("mr_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
